// File: rtl/fdiv_fsqrt_iter_pkg.sv
// Shared FPU definitions for the iterative divide / square-root unit.
package fdiv_fsqrt_iter_pkg;

    localparam int FRAC_W     = 23;          // stored fraction bits
    localparam int SIG_W      = FRAC_W + 1;  // significand incl. hidden bit
    localparam int QW         = 26;          // result: 1 integer + 25 fraction bits
    localparam int CNT_W      = 5;           // iteration counter width
    localparam int FDIV_ITERS = 26;          // one result bit per iteration
    localparam int RW         = 28;          // partial remainder width

    typedef enum logic {
        OP_DIV  = 1'b0,
        OP_SQRT = 1'b1
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Radicand bits consumed two at a time, MSB first. An odd exponent doubles
    // the radicand so the root stays in [1,2); the trailing zero pads the
    // 25-bit radicand to a whole number of digit pairs.
    function automatic logic [QW-1:0] sqrt_radicand(input logic [SIG_W-1:0] a,
                                                    input logic odd);
        return odd ? {a, 2'b00} : {1'b0, a, 1'b0};
    endfunction

endpackage

// File: rtl/fdiv_fsqrt_iter_if.sv
// Issue / result bundle between the FP execute stage and the iterative unit.
interface fdiv_fsqrt_iter_if;
    import fdiv_fsqrt_iter_pkg::*;

    logic             start;
    logic             op_sqrt;
    logic [SIG_W-1:0] a_frac;
    logic [SIG_W-1:0] b_frac;
    logic             odd_exp;
    logic [QW-1:0]    q;
    logic             sticky;
    logic             dbz;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             stall;

    modport master (
        output start, op_sqrt, a_frac, b_frac, odd_exp,
        input  q, sticky, dbz, busy, done, count, stall
    );

    modport slave (
        input  start, op_sqrt, a_frac, b_frac, odd_exp,
        output q, sticky, dbz, busy, done, count, stall
    );

endinterface

// File: rtl/fdiv_fsqrt_step.sv
// One restoring iteration: produces a single result bit and the next
// partial remainder for either divide or square root.
module fdiv_fsqrt_step
    import fdiv_fsqrt_iter_pkg::*;
(
    input  logic             op_sqrt,
    input  logic [RW-1:0]    r_in,
    input  logic [SIG_W-1:0] divisor,
    input  logic [QW-2:0]    q_part,
    input  logic [1:0]       pair,
    output logic [RW-1:0]    r_out,
    output logic             bit_out
);

    logic [RW-1:0]      src;
    logic [RW-1:0]      sub;
    logic [RW-1:0]      kept;
    logic signed [RW:0] diff;

    // Trial subtraction; a non-negative difference means the bit is 1.
    // Divide shifts after the decision, sqrt brings in the next radicand
    // pair before it and subtracts {q,01}.
    always_comb begin
        src     = op_sqrt ? {r_in[RW-3:0], pair} : r_in;
        sub     = op_sqrt ? {1'b0, q_part, 2'b01} : {{(RW-SIG_W){1'b0}}, divisor};
        diff    = $signed({1'b0, src}) - $signed({1'b0, sub});
        bit_out = ~diff[RW];
        kept    = bit_out ? diff[RW-1:0] : src;
        r_out   = op_sqrt ? kept : {kept[RW-2:0], 1'b0};
    end

endmodule

// File: rtl/fdiv_fsqrt_iter.sv
// Iterative significand divider / square-rooter, one result bit per cycle.
// Also generates the busy count and the E1 stall for the integer pipe.
module fdiv_fsqrt_iter
    import fdiv_fsqrt_iter_pkg::*;
(
    input logic              clk,
    input logic              clrn,
    fdiv_fsqrt_iter_if.slave bus
);

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic             last;
    logic             busy;
    logic             is_dbz;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             sticky;
    logic             dbz;
    logic [QW-1:0]    q_res;

    op_e              op_r;
    logic [SIG_W-1:0] b_r;
    logic [RW-1:0]    r;
    logic [QW-1:0]    rad;
    logic [QW-2:0]    qw;
    logic [RW-1:0]    r_next;
    logic             step_bit;

    assign busy   = (state == S_RUN);
    assign is_dbz = !bus.op_sqrt && (bus.b_frac == '0);

    fdiv_fsqrt_step u_step (
        .op_sqrt (op_r == OP_SQRT),
        .r_in    (r),
        .divisor (b_r),
        .q_part  (qw),
        .pair    (rad[QW-1:QW-2]),
        .r_out   (r_next),
        .bit_out (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state: accept only when idle; divide-by-zero never enters RUN.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (!is_dbz) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (count == CNT_W'(1)) begin
                    last      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control and visible result registers; q only moves on completion.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            count  <= '0;
            done   <= 1'b0;
            q_res  <= '0;
            sticky <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= last | (accept & is_dbz);
            if (accept) begin
                if (is_dbz) begin
                    q_res  <= '1;
                    sticky <= 1'b1;
                    dbz    <= 1'b1;
                    count  <= '0;
                end else begin
                    sticky <= 1'b0;
                    dbz    <= 1'b0;
                    count  <= CNT_W'(FDIV_ITERS);
                end
            end else if (busy) begin
                count <= count - CNT_W'(1);
                if (last) begin
                    q_res  <= {qw, step_bit};
                    sticky <= |r_next;
                end
            end
        end
    end

    // Iteration datapath: operand latch on accept, then one step per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= op_e'(bus.op_sqrt);
            b_r  <= bus.b_frac;
            qw   <= '0;
            if (bus.op_sqrt) begin
                r   <= '0;
                rad <= sqrt_radicand(bus.a_frac, bus.odd_exp);
            end else begin
                r   <= {{(RW-SIG_W){1'b0}}, bus.a_frac};
                rad <= '0;
            end
        end else if (busy) begin
            r   <= r_next;
            rad <= {rad[QW-3:0], 2'b00};
            qw  <= {qw[QW-3:0], step_bit};
        end
    end

    assign bus.q      = q_res;
    assign bus.sticky = sticky;
    assign bus.dbz    = dbz;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.count  = count;
    assign bus.stall  = (bus.start & ~busy) | (busy & (count != CNT_W'(1)));

endmodule
